// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg - shared encodings for the UART transmit queue (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo - single-clock FIFO with explicit level counter (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue - buffers CPU bytes and paces them into a UART transmitter (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int GAP_CYCLES = 2,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_full,
  output logic [LW-1:0]     level,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_start,
  input  logic              tx_busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e         state_q;
  logic [GW-1:0]     gap_q;
  logic [BYTE_W-1:0] tx_byte_q;
  logic              tx_start_q;
  logic              overflow_q;
  logic              overflow_d;

  logic [BYTE_W-1:0] fifo_dout;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              dropped;

  assign pop     = (state_q == ST_IDLE) && !fifo_empty;
  assign dropped = in_valid && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (reset),
    .push_i  (in_valid),
    .pop_i   (pop),
    .din_i   (in_data),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A new drop takes priority over a clear arriving in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (dropped)           overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            tx_byte_q  <= fifo_dout;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (tx_busy) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES == 0) begin
              state_q <= ST_IDLE;
            end else begin
              gap_q   <= GAP_LOAD;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_q <= ST_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_full  = fifo_full;
  assign level    = fifo_level;
  assign overflow = overflow_q;
  assign tx_byte  = tx_byte_q;
  assign tx_start = tx_start_q;

endmodule

`default_nettype wire
